oled_msg_sequencer: RTL and testbench
=====================================

Name: oled_msg_sequencer

Overview:
Parametrised message sender that feeds a byte-wide write port on the OLED controller (wr_data / wr_en), replacing the fixed one-character "hello" sequencer.
- Holds a compile-time message of up to MSG_MAX characters; the runtime length is latched at start.
- Applies a start-up delay, then an inter-character gap, and honours controller back-pressure (wr_ready).
- Reports busy, done and progress.
- Sits between the top-level wrapper and oled_controller.

Parameters:
MSG_MAX, 5, maximum message length in characters (≥1)
MSG, 40'h6F6C6C6568, packed message, MSG_MAX*8 bits; char i = MSG[8*i+7:8*i] (default "hello", byte 0 = 'h')
START_DELAY_CYCLES, 10_000_000, cycles waited before the first character (500 ms at 20 MHz); 0 allowed
CHAR_GAP_CYCLES, 0, idle cycles inserted after each accepted character
AUTO_START, 1, 1 = sequence starts automatically after reset release

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that starts a sequence when IDLE or DONE
msg_len  in  $clog2(MSG_MAX+1)  characters to send; sampled on start / auto-start
wr_ready  in  1  controller can accept a byte (tie to ~buffer_full)
wr_data  out  8  character to controller
wr_en  out  1  single-cycle write strobe
busy  out  1  high in START_WAIT, SEND and GAP
done  out  1  high in DONE
char_idx  out  $clog2(MSG_MAX+1)  index of the next character to send

Behaviour:
Reset values (asynchronous on rst_n=0): state=IDLE, wr_data=0, wr_en=0, busy=0, done=0, char_idx=0, delay counter=0.
- Reset mid-sequence aborts immediately and clears all state; no partial output is held.

States:
- IDLE:
  - AUTO_START=1: on the first clk edge after reset release, latch len and go to START_WAIT.
  - Otherwise wait for start=1.
- START_WAIT: count START_DELAY_CYCLES cycles, then go to SEND. START_DELAY_CYCLES=0 goes to SEND on the next edge.
- SEND:
  - If char_idx==len, go to DONE.
  - Else if wr_ready=1: register wr_data=char[char_idx], wr_en=1, increment char_idx.
    - Go to GAP if CHAR_GAP_CYCLES>0, else remain in SEND.
  - Else (wr_ready=0): wr_en=0 and hold; no timeout.
- GAP: count CHAR_GAP_CYCLES cycles, then return to SEND.
- DONE: done=1, wr_en=0. start=1 latches a new len, clears char_idx, and goes to START_WAIT.

Latching and strobe rules:
- len = min(msg_len, MSG_MAX), latched once per sequence; later msg_len changes are ignored.
- len=0: SEND goes straight to DONE; no wr_en is ever asserted.
- start while busy is ignored.
- wr_en is a registered output and is never high for two consecutive cycles unless CHAR_GAP_CYCLES=0 and wr_ready stays high. In that case back-to-back strobes occur, one per cycle.
- wr_data holds its last value after wr_en drops.

Timing:
- With wr_ready=1, the first wr_en is high in cycle START_DELAY_CYCLES+2 after reset release (edge 1: IDLE→START_WAIT; START_DELAY_CYCLES edges of wait; next edge registers the write).
- Consecutive strobes are CHAR_GAP_CYCLES+1 cycles apart.
- The delay counter is 32 bits, wide enough for START_DELAY_CYCLES and CHAR_GAP_CYCLES; it clears on every state entry.

Optional Feature:
Macro OLED_SEQ_LOOP_EN.
- Defined: adds input port loop_en (1 bit). If loop_en=1 when the last character is accepted, the next SEND entry clears char_idx to 0 and goes to GAP/START_WAIT instead of DONE.
  - The wait state is GAP if CHAR_GAP_CYCLES>0, else START_WAIT with the full start delay.
  - The message repeats indefinitely; done stays 0.
  - loop_en=0 at that point ends normally in DONE.
- Undefined: no loop_en port; the sequence always ends in DONE.

Test Plan:
1. MSG default, AUTO_START=1, START_DELAY_CYCLES=10, CHAR_GAP_CYCLES=3, msg_len=5, wr_ready=1.
   -> wr_en pulses carry 68,65,6C,6C,6F. First pulse in cycle 12; pulses 4 cycles apart; done=1 one cycle after the last SEND check; busy=0 afterwards.
2. Same setup, wr_ready forced low for 7 cycles just before the 3rd character.
   -> no wr_en during the stall. 6C is sent on the first cycle wr_ready=1; remaining spacing is unchanged; 5 pulses total.
3. AUTO_START=0, msg_len=0, start pulse.
   -> busy for 10 start-delay cycles then DONE; zero wr_en pulses; char_idx=0.
4. msg_len=7 (>MSG_MAX=5), CHAR_GAP_CYCLES=0.
   -> exactly 5 back-to-back wr_en cycles (68,65,6C,6C,6F), then done. A start pulse in DONE replays the message after the start delay.
5. Assert rst_n=0 right after the 2nd character, release, AUTO_START=1.
   -> outputs reset asynchronously. The sequence restarts from 'h' after the full start delay.
6. With OLED_SEQ_LOOP_EN, loop_en=1, CHAR_GAP_CYCLES=2, msg_len=2.
   -> wr_data stream 68,65,68,65,… every 3 cycles; done stays 0. Dropping loop_en before a final 'e' ends in DONE after that character.

Source files
------------

// File: rtl/oled_msg_sequencer.sv
// oled_msg_sequencer: sends a fixed message byte-by-byte to the OLED controller.
// Define OLED_SEQ_LOOP_EN to add the loop_en port for endless message repeat.
module oled_msg_sequencer #(
   parameter int unsigned          MSG_MAX            = 5,
   parameter logic [MSG_MAX*8-1:0] MSG                = 40'h6F6C6C6568,
   parameter int unsigned          START_DELAY_CYCLES = 10_000_000,
   parameter int unsigned          CHAR_GAP_CYCLES    = 0,
   parameter bit                   AUTO_START         = 1'b1,
   localparam int unsigned         LW = $clog2(MSG_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [LW-1:0] msg_len,
   input  logic          wr_ready,
`ifdef OLED_SEQ_LOOP_EN
   input  logic          loop_en,
`endif
   output logic [7:0]    wr_data,
   output logic          wr_en,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] char_idx
);

   typedef enum logic [2:0] {
      IDLE,
      START_WAIT,
      SEND,
      GAP,
      DONE
   } state_t;

   localparam logic [LW-1:0] MAX_LEN = LW'(MSG_MAX);
   localparam logic [31:0]   SD      = 32'(START_DELAY_CYCLES);
   localparam logic [31:0]   GD      = 32'(CHAR_GAP_CYCLES);
   localparam int unsigned   NCH     = 2 ** LW;

   state_t        state, state_n;
   logic [31:0]   cnt, cnt_n;
   logic [LW-1:0] idx_n;
   logic [LW-1:0] len, len_n;
   logic [LW-1:0] len_in;
   logic [7:0]    data_n;
   logic          wen_n;
   logic          arm, arm_n;
   logic          sd_hit, gd_hit;
   logic          last;
   logic          loop_req;
   logic [7:0]    chars [NCH];

   // Message bytes as an index-width-exact table; unused slots read zero.
   for (genvar g = 0; g < NCH; g++) begin : g_chr
      if (g < MSG_MAX) begin : g_v
         assign chars[g] = MSG[8*g +: 8];
      end else begin : g_z
         assign chars[g] = 8'h00;
      end
   end

`ifdef OLED_SEQ_LOOP_EN
   assign loop_req = loop_en;
`else
   assign loop_req = 1'b0;
`endif

   assign len_in = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
   assign sd_hit = (SD == 32'd0) || (cnt == SD - 32'd1);
   assign gd_hit = (GD == 32'd0) || (cnt == GD - 32'd1);
   assign last   = ((char_idx + 1'b1) == len);
   assign busy   = (state == START_WAIT) || (state == SEND) || (state == GAP);
   assign done   = (state == DONE);

   // State, counters and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         char_idx <= '0;
         len      <= '0;
         wr_data  <= '0;
         wr_en    <= 1'b0;
         arm      <= AUTO_START;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         char_idx <= idx_n;
         len      <= len_n;
         wr_data  <= data_n;
         wr_en    <= wen_n;
         arm      <= arm_n;
      end
   end

   // Next-state and next-output decode; counter clears on every state entry.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 32'd1;
      idx_n   = char_idx;
      len_n   = len;
      data_n  = wr_data;
      wen_n   = 1'b0;
      arm_n   = arm;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (arm || start) begin
               arm_n   = 1'b0;
               len_n   = len_in;
               idx_n   = '0;
               state_n = START_WAIT;
            end
         end
         START_WAIT: begin
            if (sd_hit) begin
               cnt_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            cnt_n = '0;
            if (char_idx == len) begin
               state_n = DONE;
            end else if (wr_ready) begin
               data_n = chars[char_idx];
               wen_n  = 1'b1;
               if (last && loop_req) begin
                  idx_n   = '0;
                  state_n = (GD != 32'd0) ? GAP : START_WAIT;
               end else begin
                  idx_n = char_idx + 1'b1;
                  if (GD != 32'd0) state_n = GAP;
               end
            end
         end
         GAP: begin
            if (gd_hit) begin
               cnt_n   = '0;
               state_n = SEND;
            end
         end
         DONE: begin
            cnt_n = '0;
            if (start) begin
               len_n   = len_in;
               idx_n   = '0;
               state_n = START_WAIT;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oled_msg_sequencer.sv
// tb_oled_msg_sequencer: scoreboard bench for two sequencer builds.
// Instance a: auto start, gap 3; instance b: manual start, gap 0.
module tb_oled_msg_sequencer;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic       start_a, start_b;
   logic [2:0] len_a, len_b;
   logic       rdy_a, rdy_b;
   logic [7:0] wd_a, wd_b;
   logic       we_a, we_b;
   logic       busy_a, busy_b;
   logic       done_a, done_b;
   logic [2:0] idx_a, idx_b;

   int   cyc_a, cyc_b;
   int   nchk = 0;
   int   nerr = 0;
   exp_t qa[$];
   exp_t qb[$];

   logic [7:0] txt [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

   always #5 clk = ~clk;

   oled_msg_sequencer #(
      .MSG_MAX(5), .MSG(40'h6F6C6C6568),
      .START_DELAY_CYCLES(10), .CHAR_GAP_CYCLES(3),
      .AUTO_START(1'b1)
   ) u_a (
      .clk(clk), .rst_n(rst_a), .start(start_a),
      .msg_len(len_a), .wr_ready(rdy_a),
`ifdef OLED_SEQ_LOOP_EN
      .loop_en(1'b0),
`endif
      .wr_data(wd_a), .wr_en(we_a), .busy(busy_a),
      .done(done_a), .char_idx(idx_a)
   );

   oled_msg_sequencer #(
      .MSG_MAX(5), .MSG(40'h6F6C6C6568),
      .START_DELAY_CYCLES(10), .CHAR_GAP_CYCLES(0),
      .AUTO_START(1'b0)
   ) u_b (
      .clk(clk), .rst_n(rst_b), .start(start_b),
      .msg_len(len_b), .wr_ready(rdy_b),
`ifdef OLED_SEQ_LOOP_EN
      .loop_en(1'b0),
`endif
      .wr_data(wd_b), .wr_en(we_b), .busy(busy_b),
      .done(done_b), .char_idx(idx_b)
   );

   // Cycle k = period following clock edge k after reset release.
   always @(posedge clk or negedge rst_a)
      if (!rst_a) cyc_a <= 0;
      else        cyc_a <= cyc_a + 1;

   always @(posedge clk or negedge rst_b)
      if (!rst_b) cyc_b <= 0;
      else        cyc_b <= cyc_b + 1;

   // Scoreboard monitor for instance a.
   always @(negedge clk) begin
      if (rst_a && we_a) begin
         nchk++;
         if (qa.size() == 0) begin
            nerr++;
            $display("FAIL a_extra_strobe: cyc=%0d data=%h, none expected",
                     cyc_a, wd_a);
         end else begin
            exp_t e;
            e = qa.pop_front();
            if (wd_a !== e.d || cyc_a != e.cyc) begin
               nerr++;
               $display("FAIL a_strobe: got cyc=%0d data=%h, want cyc=%0d data=%h",
                        cyc_a, wd_a, e.cyc, e.d);
            end
         end
      end
   end

   // Scoreboard monitor for instance b.
   always @(negedge clk) begin
      if (rst_b && we_b) begin
         nchk++;
         if (qb.size() == 0) begin
            nerr++;
            $display("FAIL b_extra_strobe: cyc=%0d data=%h, none expected",
                     cyc_b, wd_b);
         end else begin
            exp_t e;
            e = qb.pop_front();
            if (wd_b !== e.d || cyc_b != e.cyc) begin
               nerr++;
               $display("FAIL b_strobe: got cyc=%0d data=%h, want cyc=%0d data=%h",
                        cyc_b, wd_b, e.cyc, e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic push_a(input int c, input logic [7:0] d);
      exp_t e;
      e.cyc = c;
      e.d   = d;
      qa.push_back(e);
   endtask

   task automatic push_b(input int c, input logic [7:0] d);
      exp_t e;
      e.cyc = c;
      e.d   = d;
      qb.push_back(e);
   endtask

   task automatic wait_a(input int k);
      while (cyc_a < k) @(negedge clk);
   endtask

   task automatic wait_b(input int k);
      while (cyc_b < k) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      len_a = 3'd5; len_b = 3'd0;
      rdy_a = 1'b1; rdy_b = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_wr_data", {24'd0, wd_a}, 32'h0);
      chk("rst_wr_en",   {31'd0, we_a}, 32'h0);
      chk("rst_busy",    {31'd0, busy_a}, 32'h0);
      chk("rst_done",    {31'd0, done_a}, 32'h0);
      chk("rst_idx",     {29'd0, idx_a}, 32'h0);
      chk("rst_b_busy",  {31'd0, busy_b}, 32'h0);

      // Full message, gap 3, first strobe in cycle 12.
      for (int i = 0; i < 5; i++) push_a(12 + 4 * i, txt[i]);
      rst_a = 1'b1;
      wait_a(1);
      chk("a1_busy_wait", {31'd0, busy_a}, 32'h1);
      len_a = 3'd1;
      wait_a(31);
      chk("a1_done_early", {31'd0, done_a}, 32'h0);
      wait_a(32);
      chk("a1_done", {31'd0, done_a}, 32'h1);
      chk("a1_busy_off", {31'd0, busy_a}, 32'h0);
      chk("a1_idx", {29'd0, idx_a}, 32'h5);
      wait_a(35);
      chk("a1_all_sent", qa.size(), 32'h0);

      // Back-pressure stall before the third character.
      rst_a = 1'b0;
      len_a = 3'd5;
      @(negedge clk);
      push_a(12, txt[0]); push_a(16, txt[1]);
      push_a(25, txt[2]); push_a(29, txt[3]); push_a(33, txt[4]);
      rst_a = 1'b1;
      wait_a(17);
      rdy_a = 1'b0;
      wait_a(24);
      rdy_a = 1'b1;
      wait_a(36);
      chk("a2_done_early", {31'd0, done_a}, 32'h0);
      wait_a(37);
      chk("a2_done", {31'd0, done_a}, 32'h1);
      chk("a2_all_sent", qa.size(), 32'h0);

      // Asynchronous reset right after the second character.
      rst_a = 1'b0;
      @(negedge clk);
      push_a(12, txt[0]); push_a(16, txt[1]);
      rst_a = 1'b1;
      wait_a(16);
      #2 rst_a = 1'b0;
      #1;
      chk("a3_async_wr_en",   {31'd0, we_a}, 32'h0);
      chk("a3_async_wr_data", {24'd0, wd_a}, 32'h0);
      chk("a3_async_busy",    {31'd0, busy_a}, 32'h0);
      chk("a3_async_idx",     {29'd0, idx_a}, 32'h0);
      chk("a3_pre_sent", qa.size(), 32'h0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) push_a(12 + 4 * i, txt[i]);
      rst_a = 1'b1;
      wait_a(32);
      chk("a3_done", {31'd0, done_a}, 32'h1);
      chk("a3_all_sent", qa.size(), 32'h0);

      // Manual start, zero-length message.
      rst_b = 1'b1;
      wait_b(3);
      chk("b0_idle_busy", {31'd0, busy_b}, 32'h0);
      chk("b0_idle_done", {31'd0, done_b}, 32'h0);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_b(14);
      chk("b1_busy", {31'd0, busy_b}, 32'h1);
      chk("b1_done_early", {31'd0, done_b}, 32'h0);
      wait_b(15);
      chk("b1_done", {31'd0, done_b}, 32'h1);
      chk("b1_busy_off", {31'd0, busy_b}, 32'h0);
      chk("b1_idx", {29'd0, idx_b}, 32'h0);

      // Oversized length clamps to 5, back-to-back strobes.
      wait_b(16);
      len_b = 3'd7;
      start_b = 1'b1;
      for (int i = 0; i < 5; i++) push_b(28 + i, txt[i]);
      @(negedge clk);
      start_b = 1'b0;
      wait_b(21);
      start_b = 1'b1;
      len_b = 3'd1;
      @(negedge clk);
      start_b = 1'b0;
      wait_b(32);
      chk("b2_done_early", {31'd0, done_b}, 32'h0);
      wait_b(33);
      chk("b2_done", {31'd0, done_b}, 32'h1);
      chk("b2_idx", {29'd0, idx_b}, 32'h5);
      chk("b2_all_sent", qb.size(), 32'h0);

      // Restart from DONE with a shorter message.
      wait_b(35);
      len_b = 3'd2;
      start_b = 1'b1;
      push_b(47, txt[0]); push_b(48, txt[1]);
      @(negedge clk);
      start_b = 1'b0;
      wait_b(49);
      chk("b3_done", {31'd0, done_b}, 32'h1);
      chk("b3_idx", {29'd0, idx_b}, 32'h2);
      wait_b(52);
      chk("b3_all_sent", qb.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
